alu_exec: RTL

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_pkg.sv | 24 ++
 rtl/mul_iter.sv | 56 +++++
 rtl/alu_exec.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: ALU control codes and the
// sequencing state encoding used by alu_exec and the ALU-control decoder.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;
    localparam logic [3:0] OP_XOR = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic isMulOp(input logic [3:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier keeping the low WIDTH bits of the product.
// The first partial product is folded into the start edge so that done rises
// after MUL_CYCLES edges, letting the parent load the result on edge MUL_CYCLES.
module mul_iter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    logic             r_running;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_running <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
        end else if (start) begin
            r_running <= 1'b1;
            r_cnt     <= CW'(1);
            r_acc     <= b[0] ? a : '0;
            r_mcand   <= a << 1;
            r_mplier  <= b >> 1;
        end else if (r_running) begin
            if (r_cnt == CW'(MUL_CYCLES)) begin
                r_running <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_cnt    <= r_cnt + CW'(1);
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
        end
    end

    assign done    = r_running && (r_cnt == CW'(MUL_CYCLES));
    assign product = r_acc;

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with a valid/ready request port and a registered result
// port; single-cycle ops complete in one edge, MUL runs on mul_iter.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    state_t           r_state;
    logic             r_busy;
    logic             r_outValid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_aluRes;
    logic             w_addOvf;
    logic             w_subOvf;
    logic             w_aluOvf;
    logic             w_accept;
    logic             w_mulStart;
    logic             w_mulDone;
    logic [WIDTH-1:0] w_product;

    assign in_ready   = (r_state == ST_IDLE) && (!r_outValid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_mulStart = w_accept && isMulOp(aluctl);

    // SLT uses sign XOR overflow so it stays correct when a-b wraps.
    always_comb begin
        w_sum    = a + b;
        w_diff   = a - b;
        w_addOvf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        w_subOvf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
        w_aluRes = '0;
        w_aluOvf = 1'b0;
        case (aluctl)
            OP_AND: w_aluRes = a & b;
            OP_OR:  w_aluRes = a | b;
            OP_ADD: begin
                w_aluRes = w_sum;
                w_aluOvf = w_addOvf;
            end
            OP_SUB: begin
                w_aluRes = w_diff;
                w_aluOvf = w_subOvf;
            end
            OP_SLT: w_aluRes = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_subOvf};
            OP_NOR: w_aluRes = ~(a | b);
            OP_XOR: w_aluRes = a ^ b;
            default: begin
                w_aluRes = '0;
                w_aluOvf = 1'b0;
            end
        endcase
    end

    mul_iter #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mulStart),
        .a       (a),
        .b       (b),
        .done    (w_mulDone),
        .product (w_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mulStart) begin
                        r_state <= ST_MUL;
                        r_busy  <= 1'b1;
                    end
                end
                ST_MUL: begin
                    if (w_mulDone) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (r_outValid && out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A load takes priority over a drain so back-to-back ops keep out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_overflow <= 1'b0;
        end else if (w_accept && !isMulOp(aluctl)) begin
            r_outValid <= 1'b1;
            r_result   <= w_aluRes;
            r_zero     <= (w_aluRes == '0);
            r_overflow <= w_aluOvf;
        end else if ((r_state == ST_MUL) && w_mulDone) begin
            r_outValid <= 1'b1;
            r_result   <= w_product;
            r_zero     <= (w_product == '0);
            r_overflow <= 1'b0;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign busy      = r_busy;

endmodule
